// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: R-type opcode, M-extension funct7,
// multiply/divide operation encoding and the mul/div unit FSM states.
package riscv_pkg;

  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Encoding equals instruction funct3.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state_e;

  function automatic logic md_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready request and
// response handshakes; shift-add multiply and restoring divide on magnitudes.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit MUL_ITERATIVE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [4:0]      req_rd_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o,
  output logic [4:0]      rsp_rd_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Applies the recorded sign to the unsigned result and selects the half.
  // Divide accumulator layout: {remainder, quotient}.
  function automatic logic [XLEN-1:0] finish_result(input muldiv_op_e       op,
                                                    input logic             neg,
                                                    input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   half;
    if (!md_is_div(op)) begin
      prod = neg ? -acc : acc;
      return (op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    half = (op == MD_DIV || op == MD_DIVU) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
    return neg ? -half : half;
  endfunction

  muldiv_op_e        req_op;
  logic              accept;
  logic              sign_a, sign_b, req_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              req_div, div_by_zero, div_ovf, fast_path;
  logic [XLEN-1:0]   fast_result;
  logic [2*XLEN-1:0] array_prod;
  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0] mul_step, div_step, calc_step;

  assign req_op      = muldiv_op_e'(req_op_i);
  assign req_ready_o = (state_q == MD_IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == MD_DONE);
  assign busy_o      = (state_q != MD_IDLE);
  assign rsp_result_o = result_q;
  assign rsp_rd_o     = rd_q;

  // Request decode: magnitudes, result sign and fast-path results.
  always_comb begin
    sign_a  = req_a_i[XLEN-1] &&
              (req_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sign_b  = req_b_i[XLEN-1] && (req_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    req_neg = (req_op == MD_REM) ? sign_a : (sign_a ^ sign_b);
    mag_a   = to_mag(req_a_i, sign_a);
    mag_b   = to_mag(req_b_i, sign_b);
    req_div = md_is_div(req_op);

    div_by_zero = req_div && (req_b_i == '0);
    div_ovf     = (req_op == MD_DIV || req_op == MD_REM) &&
                  (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_b_i == '1);
    fast_path   = div_by_zero || div_ovf || (!req_div && !MUL_ITERATIVE);

    array_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    if (div_by_zero)
      fast_result = (req_op == MD_DIV || req_op == MD_DIVU) ? '1 : req_a_i;
    else if (div_ovf)
      fast_result = (req_op == MD_DIV) ? req_a_i : '0;
    else
      fast_result = finish_result(req_op, req_neg, array_prod);
  end

  // One iteration of each algorithm; opnd_q holds multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    div_step  = rem_diff[XLEN] ? {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {rem_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    calc_step = md_is_div(op_q) ? div_step : mul_step;
  end

  // NOTE: every next-state signal takes its hold value first so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          rd_d  = req_rd_i;
          neg_d = req_neg;
          cnt_d = '0;
          if (fast_path) begin
            result_d = fast_result;
            state_d  = MD_DONE;
          end else begin
            state_d = MD_CALC;
            acc_d   = {{XLEN{1'b0}}, req_div ? mag_a : mag_b};
            opnd_d  = req_div ? mag_b : mag_a;
          end
        end
      end
      MD_CALC: begin
        acc_d = calc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = finish_result(op_q, neg_q, calc_step);
          state_d  = MD_DONE;
        end
      end
      MD_DONE: begin
        if (rsp_ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    if (flush_i) state_d = MD_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: scoreboarded results, latency,
// stall, flush, async reset and a single-cycle multiply build.
module tb_riscv_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, req_valid_i, req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_a_i, req_b_i;
  logic [4:0]  req_rd_i;
  logic        rsp_valid_o, rsp_ready_i, busy_o;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_rd_o;

  logic        flush2, req_valid2, req_ready2, rsp_valid2, busy2;
  logic [2:0]  req_op2;
  logic [31:0] req_a2, req_b2, rsp_result2;
  logic [4:0]  req_rd2, rsp_rd2;

  riscv_muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(1'b1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_rd_o(rsp_rd_o), .busy_o(busy_o)
  );

  riscv_muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(1'b0)) dut_fast (
    .clk(clk), .rst(rst), .flush_i(flush2),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_op_i(req_op2),
    .req_a_i(req_a2), .req_b_i(req_b2), .req_rd_i(req_rd2),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(1'b1),
    .rsp_result_o(rsp_result2), .rsp_rd_o(rsp_rd2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference using 64-bit host arithmetic.
  function automatic logic [31:0] ref_model(input muldiv_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb_ = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    longint      ua = longint'({32'b0, a});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = sa * sb_; return p[31:0];  end
      MD_MULH:   begin p = sa * sb_; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub;  return p[63:32]; end
      MD_MULHU:  begin p = ua * ub;  return p[63:32]; end
      MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Starts at a negedge with the unit idle; returns at the negedge where
  // rsp_valid_o is first seen (or the wait budget ran out).
  task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                       input string name);
    int   cyc;
    exp_t e;
    check({name, "_req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_rd_i    = rd;
    sb.push_back('{result: exp_res, rd: rd, lat: exp_lat, name: name});
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_op_i    = 3'($urandom);
    req_a_i     = $urandom;
    req_b_i     = $urandom;
    req_rd_i    = 5'($urandom);
    cyc = 1;
    while (!rsp_valid_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({e.name, "_latency"}, 64'(cyc), 64'(e.lat));
    check({e.name, "_result"}, 64'(rsp_result_o), 64'(e.result));
    check({e.name, "_rd"}, 64'(rsp_rd_o), 64'(e.rd));
  endtask

  task automatic take(input string name);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check({name, "_idle_busy"}, 64'(busy_o), 64'd0);
    check({name, "_idle_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
  endtask

  task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                        input string name);
    issue(op, a, b, rd, exp_res, exp_lat, name);
    take(name);
  endtask

  initial begin
    int n_valid;
    logic [31:0] ra, rb;
    muldiv_op_e  rop;

    rst = 1'b1;
    flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    req_rd_i = '0; rsp_ready_i = 1'b0;
    flush2 = 1'b0; req_valid2 = 1'b0; req_op2 = '0; req_a2 = '0; req_b2 = '0; req_rd2 = '0;
    #1;
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_result", 64'(rsp_result_o), 64'd0);
    check("reset_rd", 64'(rsp_rd_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(MD_MUL, 32'd7, -32'sd3, 5'd17, 32'hFFFF_FFEB, 33, "mul_7_m3");

    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, "mulh_min");
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, "mulhu_max");
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33, "mulhsu_max");

    run_op(MD_DIV,  -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_op(MD_REM,  -32'sd7, 32'd2, 5'd5, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_op(MD_DIVU, 32'd100, 32'd7, 5'd6, 32'd14, 33, "divu_100_7");
    run_op(MD_REMU, 32'd100, 32'd7, 5'd7, 32'd2, 33, "remu_100_7");

    run_op(MD_DIV,  32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, "div_by_zero");
    run_op(MD_REMU, 32'd5, 32'd0, 5'd9, 32'd5, 1, "remu_by_zero");
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, "div_ovf");
    run_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1, "rem_ovf");
    run_op(MD_MUL,  32'd123, 32'd45, 5'd0, 32'd5535, 33, "mul_rd0");

    for (int i = 0; i < 6; i++) begin
      rop = muldiv_op_e'(3'(i + 2));
      ra  = $urandom;
      rb  = $urandom;
      run_op(rop, ra, rb, 5'(i + 20), ref_model(rop, ra, rb), 33, $sformatf("rand%0d", i));
    end

    // Response held under back-pressure, then back-to-back accept.
    issue(MD_DIVU, 32'd1000, 32'd10, 5'd12, 32'd100, 33, "stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d", i), 64'(rsp_valid_o), 64'd1);
      check($sformatf("stall_result_%0d", i), 64'(rsp_result_o), 64'd100);
      check($sformatf("stall_rd_%0d", i), 64'(rsp_rd_o), 64'd12);
      check($sformatf("stall_ready_%0d", i), 64'(req_ready_o), 64'd0);
    end
    take("stall");
    run_op(MD_MUL, 32'd100, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FF9C, 33, "after_stall");

    // Flush while idle with a request offered: not accepted.
    flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = MD_DIVU; req_a_i = 32'd9; req_b_i = 32'd3;
    #1;
    check("flush_idle_ready", 64'(req_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 1'b0;
    check("flush_idle_busy", 64'(busy_o), 64'd0);

    // Flush in cycle 10 of CALC: discarded, no response.
    req_valid_i = 1'b1; req_op_i = MD_MUL; req_a_i = 32'd3; req_b_i = 32'd4; req_rd_i = 5'd14;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_calc_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1; req_valid_i = 1'b1;
    #1;
    check("flush_calc_ready", 64'(req_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 1'b0;
    check("flush_calc_busy", 64'(busy_o), 64'd0);
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid_o) n_valid++;
    end
    check("flush_no_response", 64'(n_valid), 64'd0);
    check("flush_stays_idle", 64'(busy_o), 64'd0);

    // Async reset mid-CALC, checked before any clock edge.
    run_op(MD_MUL, 32'd7, -32'sd3, 5'd15, 32'hFFFF_FFEB, 33, "pre_reset");
    req_valid_i = 1'b1; req_op_i = MD_DIV; req_a_i = 32'd77; req_b_i = 32'd7; req_rd_i = 5'd16;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("arst_result", 64'(rsp_result_o), 64'd0);
    check("arst_rd", 64'(rsp_rd_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(MD_REMU, 32'd50, 32'd8, 5'd18, 32'd2, 33, "post_reset");

    // Single-cycle multiply build.
    req_valid2 = 1'b1; req_op2 = MD_MUL; req_a2 = 32'd7; req_b2 = -32'sd3; req_rd2 = 5'd19;
    #1;
    check("fast_req_ready", 64'(req_ready2), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 1'b1; req_op2 = MD_MULH; req_a2 = 32'h8000_0000; req_b2 = 32'h8000_0000;
    req_rd2 = 5'd20;
    check("fast_mul_valid", 64'(rsp_valid2), 64'd1);
    check("fast_mul_result", 64'(rsp_result2), 64'hFFFF_FFEB);
    check("fast_mul_rd", 64'(rsp_rd2), 64'd19);
    check("fast_mul_not_ready", 64'(req_ready2), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("fast_idle_busy", 64'(busy2), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 1'b0;
    check("fast_mulh_valid", 64'(rsp_valid2), 64'd1);
    check("fast_mulh_result", 64'(rsp_result2), 64'h4000_0000);
    check("fast_mulh_rd", 64'(rsp_rd2), 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
